// File: rtl/unary_sched_pkg.sv
// unary_sched_pkg: shared state type and constants for the unary multiplier scheduler
package unary_sched_pkg;
  localparam int INPUT_WIDTH_DEFAULT = 8;
  localparam logic [1:0] READY_FEED = 2'b11;
  localparam logic [1:0] READY_IDLE = 2'b00;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, RESP} sched_state_t;
endpackage

// File: rtl/unary_rr_arbiter.sv
// unary_rr_arbiter: 2-way round-robin arbiter, pointer holds the last granted requester
module unary_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);
  logic ptr_q, ptr_d;
  assign gnt_o = (req_i == 2'b11) ? (ptr_q ? 2'b01 : 2'b10) : req_i;
  assign ptr_d = update_i ? gnt_o[1] : ptr_q;
  assign ptr_o = ptr_q;
  // last grant = 1 out of reset so requester 0 wins the first tie
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr_q <= 1'b1;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/unary_mul_scheduler.sv
// unary_mul_scheduler: shares one unary multiplier between two requesters,
// serializing operands LSB-first and collecting the valid-qualified output bits.
module unary_mul_scheduler
  import unary_sched_pkg::*;
#(
  parameter int INPUT_WIDTH  = INPUT_WIDTH_DEFAULT,
  parameter int COUNT_WIDTH  = $clog2(INPUT_WIDTH + 1),
  parameter int DRAIN_CYCLES = INPUT_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [2*INPUT_WIDTH-1:0] req_a,
  input  logic [2*INPUT_WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [INPUT_WIDTH-1:0]   rsp_y,
  output logic [COUNT_WIDTH-1:0]   rsp_count,
  output logic                     rsp_ovf,
  output logic                     mul_reset,
  output logic                     mul_a,
  output logic                     mul_b,
  output logic [1:0]               mul_ready,
  input  logic                     mul_valid,
  input  logic                     mul_y
);
  localparam int W = INPUT_WIDTH;
  localparam int PW = $clog2((DRAIN_CYCLES > W ? DRAIN_CYCLES : W) + 1);
  sched_state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic id_q, id_d, ovf_q, ovf_d;
  logic [1:0] gnt;
  logic rr_ptr, hs, streaming, collect, full;
  unary_rr_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_valid),
    .update_i (hs),
    .gnt_o    (gnt),
    .ptr_o    (rr_ptr)
  );
  assign req_ready = (reset && state_q == IDLE) ? gnt : 2'b00;
  assign hs = |req_ready;
  assign streaming = state_q == FEED || state_q == DRAIN;
  assign collect = streaming && mul_valid;
  assign full = cnt_q == COUNT_WIDTH'(W);
  always_comb begin
    case (state_q)
      IDLE:    state_d = hs ? CLEAR : IDLE;
      CLEAR:   state_d = FEED;
      FEED:    state_d = (phase_q == PW'(W - 1)) ? DRAIN : FEED;
      DRAIN:   state_d = (phase_q == PW'(DRAIN_CYCLES - 1)) ? RESP : DRAIN;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // the pointer has advanced to the winner by CLEAR and stays put until the next grant
  always_comb begin
    phase_d = (streaming && state_d == state_q) ? phase_q + PW'(1) : '0;
    a_d = hs ? (gnt[1] ? req_a[2*W-1:W] : req_a[W-1:0]) : (state_q == FEED ? a_q >> 1 : a_q);
    b_d = hs ? (gnt[1] ? req_b[2*W-1:W] : req_b[W-1:0]) : (state_q == FEED ? b_q >> 1 : b_q);
    id_d = (state_q == CLEAR) ? rr_ptr : id_q;
    y_d = hs ? '0 : (collect && !full) ? y_q | (W'(mul_y) << cnt_q) : y_q;
    cnt_d = hs ? '0 : (collect && !full) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
    ovf_d = hs ? 1'b0 : ovf_q | (collect && full);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= 1'b0;
      y_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      a_q <= a_d;
      b_q <= b_d;
      id_q <= id_d;
      y_q <= y_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  assign mul_reset = reset && state_q != CLEAR;
  assign mul_ready = (state_q == FEED) ? READY_FEED : READY_IDLE;
  assign mul_a = state_q == FEED && a_q[0];
  assign mul_b = state_q == FEED && b_q[0];
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_y = y_q;
  assign rsp_count = cnt_q;
  assign rsp_ovf = ovf_q;
endmodule

// File: doc/unary_mul_scheduler.md
# unary_mul_scheduler

Sequencer and round-robin arbiter sharing one `UnaryMultiplier` between two requesters. It accepts binary operand words and clears the multiplier between jobs. It serializes the operands LSB-first onto `a`/`b` with `ready=2'b11`, then drains with `ready=2'b00`. It collects the `y` bits qualified by `valid` into a word and returns it with the requester id over a valid/ready response port.

## Interface
- `INPUT_WIDTH`, 8, operand and stream length in bits
- `COUNT_WIDTH`, `$clog2(INPUT_WIDTH+1)`, width of the collected-bit counter
- `DRAIN_CYCLES`, `INPUT_WIDTH+1`, number of flush cycles after the feed phase

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `req_valid`  in  2  per-requester job request
- `req_ready`  out  2  grant/accept, at most one bit high
- `req_a`  in  2*INPUT_WIDTH  operand a; requester i in bits [i*W +: W]
- `req_b`  in  2*INPUT_WIDTH  operand b, same packing
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  1  requester index of the result
- `rsp_y`  out  INPUT_WIDTH  collected stream, first valid bit at bit 0
- `rsp_count`  out  COUNT_WIDTH  number of bits collected
- `rsp_ovf`  out  1  more than INPUT_WIDTH valid bits were seen
- `mul_reset`  out  1  active-low clear to the multiplier
- `mul_a`, `mul_b`  out  1  serialized operand bits
- `mul_ready`  out  2  multiplier input qualifier
- `mul_valid`  in  1  multiplier output qualifier
- `mul_y`  in  1  multiplier output bit

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, RESP.
- **IDLE**
  - `req_ready` is combinational: high only for the arbiter's pick, and only when that `req_valid` is high.
  - Handshake (`req_valid[i] & req_ready[i]`) captures the operands and id, zeroes the accumulator, count and ovf, then goes to CLEAR.
- **Arbitration**
  - Round-robin on a last-grant pointer.
  - A single requester always wins.
  - When both are valid, the winner is the requester not granted last.
  - After reset the pointer favours requester 0.
- **CLEAR** (1 cycle): `mul_reset=0`, `mul_ready=00`, `mul_a=mul_b=0`, then go to FEED.
- **FEED** (INPUT_WIDTH cycles, bit index k=0..W-1): `mul_a=a_q[k]`, `mul_b=b_q[k]`, `mul_ready=2'b11`.
- **DRAIN** (DRAIN_CYCLES cycles): `mul_a=mul_b=0`, `mul_ready=00`.
- **Collection** (every FEED/DRAIN cycle in which `mul_valid=1`):
  - If count < W: write `mul_y` to `rsp_y[count]` and increment count.
  - Otherwise: set `rsp_ovf` (sticky) and leave count saturated at W.
  - Collection is never active in IDLE, CLEAR or RESP.
- **RESP**
  - `rsp_valid=1`; `rsp_id`, `rsp_y`, `rsp_count`, `rsp_ovf` held stable.
  - `rsp_ready` completes the transfer and returns the FSM to IDLE.
  - No new grant is issued while in RESP.
- **Reset values** (any time `reset=0`, asynchronous):
  - State IDLE, pointer favours requester 0.
  - `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_y=0`, `rsp_count=0`, `rsp_ovf=0`.
  - `mul_reset=0`, `mul_a=mul_b=0`, `mul_ready=00`.
  - Any in-flight job is dropped with no response.
- `mul_reset` is high in all states except CLEAR and reset.

## Timing
- Handshake at cycle T:
  - CLEAR at T+1.
  - FEED at T+2..T+1+W.
  - DRAIN at T+2+W..T+2+2W.
  - `rsp_valid` rises at T+3+2W, i.e. T+19 for W=8.
- Latency is fixed regardless of `mul_valid` behaviour.
- The response transfer at cycle R returns to IDLE at R+1. The earliest next grant is R+1, so jobs are 2W+4 cycles apart when back-to-back.
- The counter for phase length is separate from the collect counter. The phase counter wraps to 0 on every phase change.
- `req_valid` dropping before grant is legal and has no effect.

## Structure
- Package `unary_sched_pkg` holds:
  - the state enum `sched_state_t`;
  - default `INPUT_WIDTH`;
  - the `mul_ready` encodings `READY_FEED=2'b11` and `READY_IDLE=2'b00`.
- Sub-module `unary_rr_arbiter`: 2-way round-robin arbiter. Inputs: request vector and an update strobe. Outputs: one-hot grant and pointer.
- Top contains the FSM, operand shift registers, phase counter and collector.

## Test plan
The bench drives an "AND stub" multiplier with `mul_valid = mul_ready[0]` and `mul_y = mul_a & mul_b`, except in scenarios 4 and 5.

1. Req0 alone, a=8'hF0, b=8'h3C, `rsp_ready=1` → `rsp_valid` at T+19, `rsp_id=0`, `rsp_y=8'h30`, `rsp_count=8`, `rsp_ovf=0`, and `mul_reset` low exactly at T+1.
2. Both requesters valid continuously from reset, 4 jobs → grant order 0,1,0,1; `req_ready` never has two bits high.
3. `rsp_ready` held low 5 cycles in RESP → outputs stable, `req_ready=00` throughout, IDLE one cycle after `rsp_ready` rises.
4. Stub with `mul_valid=1` on all 17 FEED+DRAIN cycles and `mul_y=1` → `rsp_y=8'hFF`, `rsp_count=8`, `rsp_ovf=1`.
5. Stub with `mul_valid=0` always → `rsp_y=0`, `rsp_count=0`, and `rsp_valid` still at T+19.
6. `reset` pulled low at FEED bit 3 → all outputs take their reset values immediately and no response is issued. After release, a pending req1 and req0 → req0 granted first.
